// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage owning the PC and the IF/ID register toward decode.
module instruction_fetch #(
  parameter int ADDR_W = 10,
  parameter int INSTR_LEN = 32,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic [ADDR_W-1:0]    o_imem_addr,
  input  logic [INSTR_LEN-1:0] i_imem_data,
  input  logic                 i_redirect_valid,
  input  logic [PC_W-1:0]      i_redirect_pc,
  output logic                 o_if_valid,
  output logic [INSTR_LEN-1:0] o_if_instr,
  output logic [PC_W-1:0]      o_if_pc,
  input  logic                 i_id_ready,
  output logic                 o_misaligned,
  output logic [PC_W-1:0]      o_fault_pc,
  output logic [31:0]          o_fetch_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, next_state;
  logic [PC_W-1:0] pc;
  logic redir, bad, good, load, xfer;
  assign redir = i_redirect_valid && state != HALT;
  assign bad = redir && |i_redirect_pc[1:0];
  assign good = redir && !bad;
  assign load = state == RUN && !redir && (!o_if_valid || i_id_ready);
  assign xfer = o_if_valid && i_id_ready;
  assign o_imem_addr = pc[ADDR_W+1:2];
  always_comb next_state = (state == HALT || bad) ? HALT : RUN;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= BOOT;
    else state <= next_state;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      pc <= RESET_PC;
      o_if_valid <= 1'b0;
      o_if_instr <= '0;
      o_if_pc <= '0;
      o_misaligned <= 1'b0;
      o_fault_pc <= '0;
      o_fetch_cnt <= '0;
    end else begin
      // a transfer completes even when a redirect flushes the register in the same cycle
      if (xfer) o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (good) pc <= i_redirect_pc;
      else if (load) pc <= pc + PC_W'(4);
      if (redir) o_if_valid <= 1'b0;
      else if (load) o_if_valid <= 1'b1;
      if (load) begin
        o_if_instr <= i_imem_data;
        o_if_pc <= pc;
      end
      if (bad) begin
        o_misaligned <= 1'b1;
        o_fault_pc <= i_redirect_pc;
      end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plus randomized checks of the fetch stage against a behavioural model.
module tb_instruction_fetch;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [9:0] imem_addr;
  logic [31:0] imem_data, redirect_pc, if_instr, if_pc, fault_pc, fetch_cnt;
  logic redirect_valid = 1'b0, id_ready = 1'b0, if_valid, misaligned;
  logic [31:0] mem [1024];
  assign imem_data = mem[imem_addr];
  instruction_fetch dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc), .i_id_ready(id_ready),
    .o_misaligned(misaligned), .o_fault_pc(fault_pc), .o_fetch_cnt(fetch_cnt)
  );
  int checks = 0, errors = 0;
  bit m_halt, m_boot, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt, m_fault;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic compare_all();
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
    chk("fetch_cnt", fetch_cnt, m_cnt);
    chk("misaligned", 32'(misaligned), 32'(m_mis));
    chk("fault_pc", fault_pc, m_fault);
    chk("imem_addr", 32'(imem_addr), (m_pc >> 2) % 1024);
  endtask
  task automatic model_reset();
    m_halt = 0; m_boot = 1; m_valid = 0; m_mis = 0;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0; m_fault = 0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    redirect_pc = '0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc = rpc;
    id_ready = rdy;
    @(posedge clk);
    if (!m_halt) begin
      if (m_valid && rdy) m_cnt++;
      if (rv && rpc % 4 != 0) begin
        m_halt = 1; m_mis = 1; m_fault = rpc; m_valid = 0;
      end else if (rv) begin
        m_pc = rpc; m_valid = 0;
      end else if (!m_boot && (!m_valid || rdy)) begin
        m_instr = mem[(m_pc >> 2) % 1024]; m_ipc = m_pc; m_valid = 1; m_pc += 4;
      end
      m_boot = 0;
    end
    #1;
    compare_all();
  endtask
  initial begin
    int r;
    logic [31:0] rpc, held;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
    do_reset();
    chk("reset_addr", 32'(imem_addr), 32'h0);
    step(0, 0, 1);
    chk("boot_no_valid", 32'(if_valid), 32'h0);
    step(0, 0, 1);
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, 32'h1000_0000);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("stall_start_pc", if_pc, 32'h8);
    held = if_instr;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_instr", if_instr, held);
      chk("stall_cnt", fetch_cnt, 32'd2);
    end
    step(0, 0, 1);
    chk("after_stall_pc", if_pc, 32'hC);
    step(0, 0, 1);
    chk("pre_redirect_pc", if_pc, 32'h10);
    step(1, 32'h40, 1);
    chk("bubble", 32'(if_valid), 32'h0);
    chk("redirect_counted", fetch_cnt, 32'd5);
    step(0, 0, 1);
    chk("redirect_pc", if_pc, 32'h40);
    chk("redirect_instr", if_instr, 32'h1000_0010);
    step(0, 0, 0);
    step(1, 32'h80, 0);
    chk("stall_redirect_drop", 32'(if_valid), 32'h0);
    step(0, 0, 1);
    chk("stall_redirect_pc", if_pc, 32'h80);
    chk("stall_redirect_cnt", fetch_cnt, 32'd5);
    step(1, 32'hFFFF_FFFC, 1);
    chk("wrap_addr0", 32'(imem_addr), 32'h3FF);
    step(0, 0, 1);
    chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", 32'(imem_addr), 32'h0);
    step(0, 0, 1);
    chk("wrap_pc1", if_pc, 32'h0);
    step(1, 32'h22, 0);
    chk("mis_flag", 32'(misaligned), 32'h1);
    chk("mis_fault", fault_pc, 32'h22);
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h0, 1);
      chk("halt_valid", 32'(if_valid), 32'h0);
    end
    do_reset();
    chk("reset_clears_mis", 32'(misaligned), 32'h0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      rpc = $urandom;
      if (r >= 4) rpc[1:0] = 2'b00;
      if (r < 2) do_reset();
      else step(r < 15, rpc, $urandom_range(0, 3) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
